stage_tl: RTL and testbench

- Pipeline stage directly downstream of the execute stage. It consumes the execute-to-TL (EXTL) bundle and performs the data-TLB (DTLB) lookup for memory operations.
- Translates the ALU-computed virtual address to a physical address and flags DTLB misses.
- Services TLB-write instructions: writes DTLB entries locally and forwards ITLB writes to fetch.
- Registers the full bundle toward the data-cache stage with 1-cycle latency.

---
 rtl/stage_tl.sv | 207 ++++++++++++++++++++
 tb/tb_stage_tl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_tl.sv
// ---------------------------------------------------------------------------
// stage_tl : translate stage between execute and the data cache.
//
// Registers the EXTL bundle toward the cache stage (1-cycle latency), looks up
// the ALU virtual address (tl_data) in a small fully-associative DTLB, and
// services TLB-write instructions (DTLB locally, ITLB forwarded to fetch).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               hold every dc_* register, suppress TLB writes
//   flush               squash the instruction entering this cycle
//   vm_on               1 = translate memory ops, 0 = identity mapping
//   tl_*                EXTL bundle from execute
//   dc_*                registered bundle toward the cache stage
//   dc_paddr            physical address (PADDR_W bits)
//   dc_dtlb_miss        memory op missed the DTLB
//   dc_fault_vaddr      faulting virtual address on a miss, else 0
//   itlbw_valid/vpn/ppn one-cycle ITLB write toward fetch
// ---------------------------------------------------------------------------
module stage_tl #(
  parameter int DTLB_ENTRIES = 4,
  parameter int PADDR_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 vm_on,
  input  logic                 tl_thread,
  input  logic                 tl_isvalid,
  input  logic                 tl_itlb_miss,
  input  logic [31:0]          tl_pc,
  input  logic [31:0]          tl_data,
  input  logic [31:0]          tl_mul,
  input  logic [31:0]          tl_r2,
  input  logic [4:0]           tl_dst,
  input  logic                 tl_isequal,
  input  logic                 tl_flag_mem,
  input  logic                 tl_flag_store,
  input  logic                 tl_flag_isbyte,
  input  logic                 tl_flag_mul,
  input  logic                 tl_flag_reg,
  input  logic                 tl_flag_jump,
  input  logic                 tl_flag_branch,
  input  logic                 tl_flag_iret,
  input  logic [1:0]           tl_flag_tlbwrite,
  output logic                 dc_thread,
  output logic                 dc_isvalid,
  output logic                 dc_itlb_miss,
  output logic [31:0]          dc_pc,
  output logic [31:0]          dc_data,
  output logic [31:0]          dc_mul,
  output logic [31:0]          dc_r2,
  output logic [4:0]           dc_dst,
  output logic                 dc_isequal,
  output logic                 dc_flag_mem,
  output logic                 dc_flag_store,
  output logic                 dc_flag_isbyte,
  output logic                 dc_flag_mul,
  output logic                 dc_flag_reg,
  output logic                 dc_flag_jump,
  output logic                 dc_flag_branch,
  output logic                 dc_flag_iret,
  output logic [PADDR_W-1:0]   dc_paddr,
  output logic                 dc_dtlb_miss,
  output logic [31:0]          dc_fault_vaddr,
  output logic                 itlbw_valid,
  output logic [19:0]          itlbw_vpn,
  output logic [PADDR_W-13:0]  itlbw_ppn
);

  localparam int PTR_W = $clog2(DTLB_ENTRIES);
  localparam int PPN_W = PADDR_W - 12;

  // DTLB storage: the arrays hold contents only, validity lives in valid_reg
  // so only that vector and the pointer need a reset.
  logic [19:0]             vpn_reg [DTLB_ENTRIES];
  logic [PPN_W-1:0]        ppn_reg [DTLB_ENTRIES];
  logic [DTLB_ENTRIES-1:0] valid_reg;
  logic [PTR_W-1:0]        ptr_reg;

  logic [DTLB_ENTRIES-1:0] hit_vec;
  logic                    lookup_hit;
  logic [PTR_W-1:0]        hit_idx;
  logic [PPN_W-1:0]        hit_ppn;

  genvar gi;
  generate
    for (gi = 0; gi < DTLB_ENTRIES; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi] && (vpn_reg[gi] == tl_data[31:12]);
    end
  endgenerate

  assign lookup_hit = |hit_vec;

  // Writes never create a duplicate VPN, so hit_vec is at most one-hot and
  // an OR-reduction yields the matching index and ppn directly.
  always_comb begin
    hit_idx = '0;
    hit_ppn = '0;
    for (int i = 0; i < DTLB_ENTRIES; i++) begin
      if (hit_vec[i]) begin
        hit_idx = hit_idx | PTR_W'(i);
        hit_ppn = hit_ppn | ppn_reg[i];
      end
    end
  end

  logic               translate;
  logic               miss_next;
  logic [PADDR_W-1:0] paddr_next;
  logic [31:0]        fault_next;
  logic               advance;
  logic               dtlb_we;
  logic               itlb_we;
  logic [PTR_W-1:0]   wr_idx;

  assign translate  = tl_isvalid && tl_flag_mem && vm_on;
  assign miss_next  = translate && !lookup_hit;
  assign paddr_next = !translate ? tl_data[PADDR_W-1:0] :
                      lookup_hit ? {hit_ppn, tl_data[11:0]} : '0;
  assign fault_next = miss_next ? tl_data : 32'd0;

  assign advance = !stall && !flush;
  assign dtlb_we = advance && tl_isvalid && (tl_flag_tlbwrite == 2'd2);
  assign itlb_we = advance && tl_isvalid && (tl_flag_tlbwrite == 2'd1);
  // Rewriting an existing VPN reuses its slot, which keeps entries unique.
  assign wr_idx  = lookup_hit ? hit_idx : ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      ptr_reg   <= '0;
    end else if (dtlb_we) begin
      valid_reg[wr_idx] <= 1'b1;
      if (!lookup_hit) begin
        ptr_reg <= ptr_reg + 1'b1;  // power-of-two depth: wraps naturally
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dtlb_we) begin
      vpn_reg[wr_idx] <= tl_data[31:12];
      ppn_reg[wr_idx] <= tl_r2[PADDR_W-1:12];
    end
  end

  // Output registers. flush outranks stall: a flushed slot still loads, but
  // as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_thread      <= 1'b0;
      dc_isvalid     <= 1'b0;
      dc_itlb_miss   <= 1'b0;
      dc_pc          <= '0;
      dc_data        <= '0;
      dc_mul         <= '0;
      dc_r2          <= '0;
      dc_dst         <= '0;
      dc_isequal     <= 1'b0;
      dc_flag_mem    <= 1'b0;
      dc_flag_store  <= 1'b0;
      dc_flag_isbyte <= 1'b0;
      dc_flag_mul    <= 1'b0;
      dc_flag_reg    <= 1'b0;
      dc_flag_jump   <= 1'b0;
      dc_flag_branch <= 1'b0;
      dc_flag_iret   <= 1'b0;
      dc_paddr       <= '0;
      dc_dtlb_miss   <= 1'b0;
      dc_fault_vaddr <= '0;
      itlbw_valid    <= 1'b0;
      itlbw_vpn      <= '0;
      itlbw_ppn      <= '0;
    end else begin
      itlbw_valid <= itlb_we;
      if (itlb_we) begin
        itlbw_vpn <= tl_data[31:12];
        itlbw_ppn <= tl_r2[PADDR_W-1:12];
      end
      if (flush || !stall) begin
        dc_thread      <= tl_thread;
        dc_isvalid     <= tl_isvalid && !flush;
        dc_itlb_miss   <= tl_itlb_miss;
        dc_pc          <= tl_pc;
        dc_data        <= tl_data;
        dc_mul         <= tl_mul;
        dc_r2          <= tl_r2;
        dc_dst         <= tl_dst;
        dc_isequal     <= tl_isequal;
        dc_flag_mem    <= tl_flag_mem;
        dc_flag_store  <= tl_flag_store;
        dc_flag_isbyte <= tl_flag_isbyte;
        dc_flag_mul    <= tl_flag_mul;
        dc_flag_reg    <= tl_flag_reg;
        dc_flag_jump   <= tl_flag_jump;
        dc_flag_branch <= tl_flag_branch;
        dc_flag_iret   <= tl_flag_iret;
        dc_paddr       <= paddr_next;
        dc_dtlb_miss   <= miss_next && !flush;
        dc_fault_vaddr <= fault_next;
      end
    end
  end

endmodule

// File: tb/tb_stage_tl.sv
// ---------------------------------------------------------------------------
// tb_stage_tl : randomized + directed bench for stage_tl. A table-level TLB
// model (slots plus a round-robin pointer) predicts every registered output.
// ---------------------------------------------------------------------------
module tb_stage_tl;

  localparam int N  = 4;
  localparam int PW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, vm_on;
  logic tl_thread, tl_isvalid, tl_itlb_miss, tl_isequal;
  logic [31:0] tl_pc, tl_data, tl_mul, tl_r2;
  logic [4:0]  tl_dst;
  logic [7:0]  tl_flags;  // {mem,store,isbyte,mul,reg,jump,branch,iret}
  logic [1:0]  tl_flag_tlbwrite;

  logic dc_thread, dc_isvalid, dc_itlb_miss, dc_isequal;
  logic [31:0] dc_pc, dc_data, dc_mul, dc_r2, dc_fault_vaddr;
  logic [4:0]  dc_dst;
  logic dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_mul;
  logic dc_flag_reg, dc_flag_jump, dc_flag_branch, dc_flag_iret;
  logic [PW-1:0] dc_paddr;
  logic dc_dtlb_miss, itlbw_valid;
  logic [19:0] itlbw_vpn;
  logic [PW-13:0] itlbw_ppn;

  stage_tl #(.DTLB_ENTRIES(N), .PADDR_W(PW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .vm_on(vm_on),
    .tl_thread(tl_thread), .tl_isvalid(tl_isvalid), .tl_itlb_miss(tl_itlb_miss),
    .tl_pc(tl_pc), .tl_data(tl_data), .tl_mul(tl_mul), .tl_r2(tl_r2),
    .tl_dst(tl_dst), .tl_isequal(tl_isequal),
    .tl_flag_mem(tl_flags[7]), .tl_flag_store(tl_flags[6]),
    .tl_flag_isbyte(tl_flags[5]), .tl_flag_mul(tl_flags[4]),
    .tl_flag_reg(tl_flags[3]), .tl_flag_jump(tl_flags[2]),
    .tl_flag_branch(tl_flags[1]), .tl_flag_iret(tl_flags[0]),
    .tl_flag_tlbwrite(tl_flag_tlbwrite),
    .dc_thread(dc_thread), .dc_isvalid(dc_isvalid), .dc_itlb_miss(dc_itlb_miss),
    .dc_pc(dc_pc), .dc_data(dc_data), .dc_mul(dc_mul), .dc_r2(dc_r2),
    .dc_dst(dc_dst), .dc_isequal(dc_isequal),
    .dc_flag_mem(dc_flag_mem), .dc_flag_store(dc_flag_store),
    .dc_flag_isbyte(dc_flag_isbyte), .dc_flag_mul(dc_flag_mul),
    .dc_flag_reg(dc_flag_reg), .dc_flag_jump(dc_flag_jump),
    .dc_flag_branch(dc_flag_branch), .dc_flag_iret(dc_flag_iret),
    .dc_paddr(dc_paddr), .dc_dtlb_miss(dc_dtlb_miss),
    .dc_fault_vaddr(dc_fault_vaddr),
    .itlbw_valid(itlbw_valid), .itlbw_vpn(itlbw_vpn), .itlbw_ppn(itlbw_ppn)
  );

  // ---------------- reference model ----------------
  bit          m_valid [N];
  logic [19:0] m_vpn   [N];
  logic [7:0]  m_ppn   [N];
  int          m_ptr;

  logic [143:0] e_pass;   // carried fields, same packing as pass_act()
  logic         e_isvalid, e_miss, e_itlbv;
  logic [PW-1:0] e_paddr;
  logic [31:0]  e_fault;
  logic [19:0]  e_ivpn;
  logic [7:0]   e_ippn;
  bit           chk_addr;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [143:0] pass_in();
    return {tl_thread, tl_itlb_miss, tl_pc, tl_data, tl_mul, tl_r2, tl_dst,
            tl_isequal, tl_flags};
  endfunction

  function automatic logic [143:0] pass_act();
    return {dc_thread, dc_itlb_miss, dc_pc, dc_data, dc_mul, dc_r2, dc_dst,
            dc_isequal, dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_mul,
            dc_flag_reg, dc_flag_jump, dc_flag_branch, dc_flag_iret};
  endfunction

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Predict the next registered state from the current inputs, advance one
  // clock, then compare every output against the prediction.
  task automatic cycle();
    int  hit_slot = -1;
    bit  do_load;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_vpn[i] == tl_data[31:12]) hit_slot = i;
    chk_addr = 1'b1;
    if (rst) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ptr = 0;
      e_pass = '0; e_isvalid = 0; e_miss = 0; e_itlbv = 0;
      e_paddr = '0; e_fault = '0; e_ivpn = '0; e_ippn = '0;
    end else begin
      do_load = flush || !stall;
      e_itlbv = 0;
      if (do_load) begin
        bit xl = tl_isvalid && tl_flags[7] && vm_on;
        e_pass    = pass_in();
        e_isvalid = tl_isvalid && !flush;
        e_miss    = xl && hit_slot < 0 && !flush;
        if (!xl)              e_paddr = tl_data[PW-1:0];
        else if (hit_slot>=0) e_paddr = {m_ppn[hit_slot], tl_data[11:0]};
        else                  e_paddr = '0;
        e_fault  = (xl && hit_slot < 0) ? tl_data : 32'd0;
        chk_addr = !flush;
      end
      if (!flush && !stall && tl_isvalid) begin
        if (tl_flag_tlbwrite == 2'd1) begin
          e_itlbv = 1; e_ivpn = tl_data[31:12]; e_ippn = tl_r2[19:12];
        end else if (tl_flag_tlbwrite == 2'd2) begin
          int s = (hit_slot >= 0) ? hit_slot : m_ptr;
          if (hit_slot < 0) m_ptr = (m_ptr + 1) % N;
          m_valid[s] = 1; m_vpn[s] = tl_data[31:12]; m_ppn[s] = tl_r2[19:12];
        end
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    chk("pass", pass_act(), e_pass);
    chk("isvalid", dc_isvalid, e_isvalid);
    chk("dtlb_miss", dc_dtlb_miss, e_miss);
    chk("itlbw_valid", itlbw_valid, e_itlbv);
    if (e_itlbv) begin
      chk("itlbw_vpn", itlbw_vpn, e_ivpn);
      chk("itlbw_ppn", itlbw_ppn, e_ippn);
    end
    if (chk_addr) begin
      chk("paddr", dc_paddr, e_paddr);
      chk("fault_vaddr", dc_fault_vaddr, e_fault);
    end
    $display("vec %0d rst=%0b st=%0b fl=%0b v=%0b tw=%0d va=%h -> pa=%h miss=%0b iw=%0b",
             n_vec, rst, stall, flush, tl_isvalid, tl_flag_tlbwrite, tl_data,
             dc_paddr, dc_dtlb_miss, itlbw_valid);
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; vm_on = 1;
    tl_thread = 0; tl_isvalid = 0; tl_itlb_miss = 0; tl_isequal = 0;
    tl_pc = 0; tl_data = 0; tl_mul = 0; tl_r2 = 0; tl_dst = 0;
    tl_flags = 0; tl_flag_tlbwrite = 0;
  endtask

  task automatic load(input logic [31:0] va);
    idle(); tl_isvalid = 1; tl_flags = 8'h80; tl_data = va; tl_pc = va ^ 32'h1000;
    cycle();
  endtask

  task automatic tlbw(input logic [1:0] kind, input logic [31:0] va, input logic [31:0] r2);
    idle(); tl_isvalid = 1; tl_flag_tlbwrite = kind; tl_data = va; tl_r2 = r2;
    cycle();
  endtask

  initial begin
    idle(); rst = 1; cycle(); cycle();
    idle(); cycle();
    chk("lit_reset_isvalid", dc_isvalid, 0);
    chk("lit_reset_paddr", dc_paddr, 0);

    // cold miss
    load(32'h0000_5123);
    chk("lit_miss", dc_dtlb_miss, 1);
    chk("lit_fault", dc_fault_vaddr, 32'h0000_5123);
    chk("lit_miss_pa", dc_paddr, 0);

    // fill then hit
    tlbw(2'd2, 32'h0000_5000, 32'h000A_7000);
    load(32'h0000_5123);
    chk("lit_hit_pa", dc_paddr, 20'hA7123);
    chk("lit_hit_miss", dc_dtlb_miss, 0);

    // replacement wrap: 5 writes into 4 slots
    idle(); rst = 1; cycle();
    for (int v = 1; v <= 5; v++) tlbw(2'd2, v << 12, (v + 16) << 12);
    load(32'h0000_1040);
    chk("lit_evict_vpn1", dc_dtlb_miss, 1);
    for (int v = 2; v <= 5; v++) begin
      load((v << 12) | 32'h0AB);
      chk("lit_keep_vpn", dc_paddr, ((v + 16) << 12) | 32'h0AB);
    end
    tlbw(2'd2, 32'h0000_3000, 32'h0003_3000);
    load(32'h0000_3004);
    chk("lit_rewrite_pa", dc_paddr, 20'h33004);
    tlbw(2'd2, 32'h0000_6000, 32'h0006_6000);  // pointer still at slot holding VPN 2
    load(32'h0000_2000);
    chk("lit_ptr_kept", dc_dtlb_miss, 1);
    load(32'h0000_4000);
    chk("lit_vpn4_alive", dc_dtlb_miss, 0);

    // ITLB write
    tlbw(2'd1, 32'h0040_0000, 32'h0001_2000);
    chk("lit_itlbw_v", itlbw_valid, 1);
    chk("lit_itlbw_vpn", itlbw_vpn, 20'h00400);
    chk("lit_itlbw_ppn", itlbw_ppn, 8'h12);
    load(32'h0040_0000);
    chk("lit_itlbw_pulse", itlbw_valid, 0);
    chk("lit_itlb_not_dtlb", dc_dtlb_miss, 1);

    // stall for 3 cycles with a dtlbwrite among changing inputs
    for (int k = 0; k < 3; k++) begin
      idle(); stall = 1; tl_isvalid = 1; tl_pc = 32'hC0 + k;
      tl_data = 32'h0000_7000; tl_r2 = 32'h0007_7000; tl_flag_tlbwrite = 2'd2;
      cycle();
      chk("lit_stall_pc", dc_pc, 32'h0040_0000 ^ 32'h1000);
    end
    load(32'h0000_7000);
    chk("lit_stall_nowrite", dc_dtlb_miss, 1);
    idle(); stall = 1; flush = 1; tl_isvalid = 1; cycle();
    chk("lit_flush_stall", dc_isvalid, 0);

    // identity mapping
    idle(); vm_on = 0; tl_isvalid = 1; tl_flags = 8'h80; tl_data = 32'hFFFF_F123; cycle();
    chk("lit_vmoff_pa", dc_paddr, 20'hFF123);
    chk("lit_vmoff_miss", dc_dtlb_miss, 0);

    // reset drops a concurrent write and invalidates all entries
    idle(); rst = 1; tl_isvalid = 1; tl_flag_tlbwrite = 2'd2;
    tl_data = 32'h0000_8000; tl_r2 = 32'h0008_8000; cycle();
    load(32'h0000_8000);
    chk("lit_rst_drop", dc_dtlb_miss, 1);
    load(32'h0000_4000);
    chk("lit_rst_clear", dc_dtlb_miss, 1);

    // randomized traffic over a small VPN pool so hits are frequent
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(63) == 0);
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(9) == 0);
      vm_on = ($urandom_range(7) != 0);
      tl_thread = $urandom; tl_itlb_miss = $urandom; tl_isequal = $urandom;
      tl_isvalid = ($urandom_range(3) != 0);
      tl_pc = $urandom; tl_mul = $urandom; tl_r2 = $urandom; tl_dst = $urandom;
      tl_flags = $urandom;
      tl_flag_tlbwrite = $urandom;
      tl_data = {12'h0, $urandom_range(7) == 0 ? 8'($urandom) : 8'($urandom_range(7)),
                 12'($urandom)};
      if ($urandom_range(15) == 0) tl_data = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
